dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory/IO block between the
// CPU datapath (port A) and the loader/debug port (port B).
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | sampling requests; registers the winner's access at the edge
// GRANT   | memory strobe active for one cycle; owner acked at the edge
module dmem_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t state_q;
    state_t state_d;
    logic   owner_q;
    logic   last_q;

    logic                  a_elig;
    logic                  b_elig;
    logic                  win_valid;
    logic                  win_port;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    logic grant_load;
    logic write_d;
    logic read_d;
    logic a_ack_d;
    logic b_ack_d;
    logic a_cap;
    logic b_cap;

    // A port whose ack is showing still holds req for the access just finished.
    always_comb begin
        a_elig    = a_req & ~a_ack;
        b_elig    = b_req & ~b_ack;
        win_valid = a_elig | b_elig;
        win_port  = PORT_A;
        if (a_elig && b_elig) begin
            win_port = FIXED_PRIORITY ? PORT_A : ~last_q;
        end else if (b_elig) begin
            win_port = PORT_B;
        end
        win_write = (win_port == PORT_B) ? b_write : a_write;
        win_addr  = (win_port == PORT_B) ? b_addr  : a_addr;
        win_wdata = (win_port == PORT_B) ? b_wdata : a_wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_A;
            last_q  <= PORT_B;
        end else begin
            state_q <= state_d;
            if (grant_load) begin
                owner_q <= win_port;
                last_q  <= win_port;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_load = 1'b0;
        write_d    = 1'b0;
        read_d     = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_cap      = 1'b0;
        b_cap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_load = 1'b1;
                    write_d    = win_write;
                    read_d     = ~win_write;
                end
            end
            ST_GRANT: begin
                a_ack_d = (owner_q == PORT_A);
                b_ack_d = (owner_q == PORT_B);
                a_cap   = a_ack_d & mem_read;
                b_cap   = b_ack_d & mem_read;
            end
            default: ;
        endcase
    end

    // Address/data stay on the pins between accesses; only the strobes drop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            mem_write <= write_d;
            mem_read  <= read_d;
            a_ack     <= a_ack_d;
            b_ack     <= b_ack_d;
            if (grant_load) begin
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
            if (a_cap) a_rdata <= mem_rdata;
            if (b_cap) b_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance with a memory model and a
// per-port scoreboard, plus a fixed-priority instance exercised directly.
module tb_dmem_arbiter;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_req, a_write, b_req, b_write;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack, mem_write, mem_read;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        f_a_req, f_a_write, f_b_req, f_b_write;
    logic [15:0] f_a_addr, f_a_wdata, f_b_addr, f_b_wdata;
    logic        f_a_ack, f_b_ack, f_mem_write, f_mem_read;
    logic [15:0] f_a_rdata, f_b_rdata, f_mem_addr, f_mem_wdata;
    logic [15:0] f_mem_rdata = 16'h1234;

    logic [15:0] mem_arr [0:65535];
    logic [15:0] shadow  [0:65535];
    logic [15:0] last_rd [0:1];

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   grant_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic        prev_strobe = 1'b0, prev_a_ack = 1'b0, prev_b_ack = 1'b0;
    logic        s_wr;
    logic [15:0] s_addr, s_wdata;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(1'b0)) u_rr (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .FIXED_PRIORITY(1'b1)) u_fp (
        .clock(clock), .reset_n(reset_n),
        .a_req(f_a_req), .a_write(f_a_write), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
        .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_write(f_b_write), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
        .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
        .mem_read(f_mem_read), .mem_rdata(f_mem_rdata)
    );

    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clock) if (mem_write) mem_arr[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_txn(input string p, input exp_t e, input logic [15:0] rd);
        check({p, "_mem_write"}, s_wr, e.wr);
        check({p, "_mem_addr"}, s_addr, e.addr);
        if (e.wr) check({p, "_mem_wdata"}, s_wdata, e.wdata);
        check({p, "_rdata"}, rd, e.rdata);
    endtask

    // Scoreboard: acks pop the owning port's queue; the strobe seen the cycle before is the access.
    always @(negedge clock) begin
        exp_t e;
        if (a_ack) begin
            check("a_ack_pulse", prev_a_ack, 1'b0);
            grant_log.push_back(0);
            if (exp_a.size() == 0) check("a_unexpected_ack", 1, 0);
            else begin e = exp_a.pop_front(); check_txn("a", e, a_rdata); end
        end
        if (b_ack) begin
            check("b_ack_pulse", prev_b_ack, 1'b0);
            grant_log.push_back(1);
            if (exp_b.size() == 0) check("b_unexpected_ack", 1, 0);
            else begin e = exp_b.pop_front(); check_txn("b", e, b_rdata); end
        end
        if (mem_write || mem_read) begin
            check("strobe_exclusive", mem_write & mem_read, 1'b0);
            check("strobe_pulse", prev_strobe, 1'b0);
            s_wr    = mem_write;
            s_addr  = mem_addr;
            s_wdata = mem_wdata;
        end
        prev_strobe = mem_write | mem_read;
        prev_a_ack  = a_ack;
        prev_b_ack  = b_ack;
    end

    task automatic push_exp(input bit port, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata);
        exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata;
        if (wr) shadow[addr] = wdata;
        else    last_rd[port] = shadow[addr];
        e.rdata = last_rd[port];
        if (port) exp_b.push_back(e);
        else      exp_a.push_back(e);
    endtask

    task automatic wait_ack(input bit port, input int t0, input int lat);
        bit got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clock);
            if (port ? b_ack : a_ack) got = 1;
        end
        if (!got) check(port ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        else if (lat != 0) check(port ? "b_latency" : "a_latency", cyc - t0, lat);
    endtask

    task automatic do_op(input bit port, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, input bit hold);
        int t0;
        @(posedge clock); #1;
        if (port) begin b_write = wr; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
        else      begin a_write = wr; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
        push_exp(port, wr, addr, wdata);
        t0 = cyc;
        wait_ack(port, t0, lat);
        if (!hold) begin
            @(posedge clock); #1;
            if (port) b_req = 1'b0; else a_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        a_req = 0; b_req = 0; f_a_req = 0; f_b_req = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        grant_log.delete();
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_queues_empty", exp_a.size() + exp_b.size(), 0);
    endtask

    initial begin
        int t0;
        bit got;
        a_write = 0; a_addr = 0; a_wdata = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        f_a_write = 0; f_a_addr = 0; f_a_wdata = 0; f_b_write = 0; f_b_addr = 0; f_b_wdata = 0;
        mem_arr[16'hfff0] = 16'h0003;
        shadow[16'hfff0]  = 16'h0003;
        do_reset();

        do_op(0, 1'b1, 16'h0004, 16'hBEEF, 2, 0);
        do_op(0, 1'b0, 16'h0004, 16'h0000, 2, 0);
        do_op(1, 1'b0, 16'hfff0, 16'h0000, 2, 0);
        do_op(1, 1'b1, 16'hfffa, 16'h005B, 2, 0);
        do_op(0, 1'b1, 16'h0006, 16'h1357, 2, 0);
        check("io_store_landed", mem_arr[16'hfffa], 16'h005B);

        // Both ports from reset: A first, then strict alternation.
        do_reset();
        fork
            begin
                do_op(0, 1'b1, 16'h0010, 16'h1111, 2, 1);
                do_op(0, 1'b0, 16'h0004, 16'h0000, 3, 0);
            end
            begin
                do_op(1, 1'b1, 16'h0020, 16'h2222, 4, 1);
                do_op(1, 1'b0, 16'h0020, 16'h0000, 3, 0);
            end
        join
        check("rr_grants", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("rr_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0],
                               grant_log[3][3:0]}, 16'h0101);
        end

        // Reset during the GRANT cycle of an A load aborts it; held req is re-served.
        @(posedge clock); #1;
        a_write = 0; a_addr = 16'h0004; a_req = 1'b1;
        @(posedge clock); #1;
        check("mid_grant_read", mem_read, 1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("abort_ack", a_ack, 0);
        check("abort_read", mem_read, 0);
        check("abort_rdata", a_rdata, 0);
        reset_n = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        push_exp(0, 1'b0, 16'h0004, 16'h0000);
        t0 = cyc;
        wait_ack(0, t0, 2);
        @(posedge clock); #1;
        a_req = 1'b0;

        // Fixed priority: A last granted, then a tie still goes to A.
        @(posedge clock); #1;
        f_a_write = 0; f_a_addr = 16'h0001; f_a_req = 1'b1;
        t0 = cyc; got = 0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clock); got = f_a_ack; end
        check("fp_solo_latency", got ? cyc - t0 : -1, 2);
        check("fp_a_rdata", f_a_rdata, 16'h1234);
        @(posedge clock); #1;
        f_a_req = 1'b0;
        @(posedge clock); #1;
        f_a_req = 1'b1; f_b_write = 0; f_b_addr = 16'h0002; f_b_req = 1'b1;
        t0 = cyc; got = 0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clock); got = f_a_ack | f_b_ack; end
        check("fp_tie_latency", got ? cyc - t0 : -1, 2);
        check("fp_tie_acks", {f_a_ack, f_b_ack}, 2'b10);
        @(posedge clock); #1;
        f_a_req = 1'b0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin @(negedge clock); got = f_b_ack; end
        check("fp_b_latency", got ? cyc - t0 : -1, 4);
        check("fp_b_rdata", f_b_rdata, 16'h1234);
        @(posedge clock); #1;
        f_b_req = 1'b0;

        repeat (3) @(posedge clock);
        check("final_queues_empty", exp_a.size() + exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
